// File: rtl/main_fsm.sv
// Multicycle processor main control FSM.
// Control outputs are registered alongside the state; pcWrite and illegal also look at live inputs.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic [1:0] aluOp,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] resultSrc,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic       pcWrite,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] opLw   = 7'b0000011;
    localparam logic [6:0] opSw   = 7'b0100011;
    localparam logic [6:0] opR    = 7'b0110011;
    localparam logic [6:0] opI    = 7'b0010011;
    localparam logic [6:0] opJal  = 7'b1101111;
    localparam logic [6:0] opBeq  = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } stateT;

    typedef struct packed {
        logic [1:0] aluOp;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic       adrSrc;
        logic       irWrite;
        logic       regWrite;
        logic       memWrite;
        logic       pcUpdate;
        logic       branch;
    } ctrlT;

    stateT stateQ;
    ctrlT  ctrlQ;

    function automatic logic isLegal(logic [6:0] o);
        return (o == opLw) || (o == opSw) || (o == opR) || (o == opI) ||
               (o == opJal) || (o == opBeq);
    endfunction

    function automatic stateT nextOf(stateT s, logic [6:0] o);
        stateT n;
        n = FETCH;
        case (s)
            FETCH:   n = DECODE;
            DECODE: begin
                if (o == opLw || o == opSw) n = MEMADR;
                else if (o == opR)          n = EXECR;
                else if (o == opI)          n = EXECI;
                else if (o == opJal)        n = JAL;
                else if (o == opBeq)        n = BEQ;
                else                        n = FETCH;
            end
            MEMADR:  n = (o == opLw) ? MEMREAD : MEMWRITE;
            MEMREAD: n = MEMWB;
            EXECR:   n = ALUWB;
            EXECI:   n = ALUWB;
            JAL:     n = ALUWB;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    // Codes 11-15 fall into the default arm: everything low.
    function automatic ctrlT ctrlOf(stateT s);
        ctrlT c;
        c = '0;
        case (s)
            FETCH: begin
                c.irWrite  = 1'b1;
                c.aluSrcB  = 2'b10;
                c.resultSrc = 2'b10;
                c.pcUpdate = 1'b1;
            end
            DECODE: begin
                c.aluSrcA = 2'b01;
                c.aluSrcB = 2'b01;
            end
            MEMADR: begin
                c.aluSrcA = 2'b10;
                c.aluSrcB = 2'b01;
            end
            MEMREAD:  c.adrSrc = 1'b1;
            MEMWB: begin
                c.resultSrc = 2'b01;
                c.regWrite  = 1'b1;
            end
            MEMWRITE: begin
                c.adrSrc   = 1'b1;
                c.memWrite = 1'b1;
            end
            EXECR: begin
                c.aluSrcA = 2'b10;
                c.aluOp   = 2'b10;
            end
            EXECI: begin
                c.aluSrcA = 2'b10;
                c.aluSrcB = 2'b01;
                c.aluOp   = 2'b10;
            end
            ALUWB:    c.regWrite = 1'b1;
            JAL: begin
                c.aluSrcA  = 2'b01;
                c.aluSrcB  = 2'b10;
                c.pcUpdate = 1'b1;
            end
            BEQ: begin
                c.aluSrcA = 2'b10;
                c.aluOp   = 2'b01;
                c.branch  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= FETCH;
            ctrlQ  <= ctrlOf(FETCH);
        end else begin
            stateQ <= nextOf(stateQ, op);
            ctrlQ  <= ctrlOf(nextOf(stateQ, op));
        end
    end

    assign aluOp     = ctrlQ.aluOp;
    assign aluSrcA   = ctrlQ.aluSrcA;
    assign aluSrcB   = ctrlQ.aluSrcB;
    assign resultSrc = ctrlQ.resultSrc;
    assign adrSrc    = ctrlQ.adrSrc;
    assign irWrite   = ctrlQ.irWrite;
    assign regWrite  = ctrlQ.regWrite;
    assign memWrite  = ctrlQ.memWrite;
    assign pcWrite   = ctrlQ.pcUpdate | (ctrlQ.branch & zero);
    assign illegal   = (stateQ == DECODE) && !isLegal(op);
    assign state     = stateQ;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized instruction stream against a table-driven model of the control FSM.
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic [1:0] aluOp, aluSrcA, aluSrcB, resultSrc;
    logic       adrSrc, irWrite, regWrite, memWrite, pcWrite, illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .resultSrc(resultSrc),
        .adrSrc(adrSrc), .irWrite(irWrite), .regWrite(regWrite), .memWrite(memWrite),
        .pcWrite(pcWrite), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, regWrite, memWrite} per state.
    function automatic logic [11:0] expCtrl(int s);
        case (s)
            0:  return {2'b00, 2'b00, 2'b10, 2'b10, 4'b0100};
            1:  return {2'b00, 2'b01, 2'b01, 2'b00, 4'b0000};
            2:  return {2'b00, 2'b10, 2'b01, 2'b00, 4'b0000};
            3:  return {2'b00, 2'b00, 2'b00, 2'b00, 4'b1000};
            4:  return {2'b00, 2'b00, 2'b00, 2'b01, 4'b0010};
            5:  return {2'b00, 2'b00, 2'b00, 2'b00, 4'b1001};
            6:  return {2'b10, 2'b10, 2'b00, 2'b00, 4'b0000};
            7:  return {2'b00, 2'b00, 2'b00, 2'b00, 4'b0010};
            8:  return {2'b10, 2'b10, 2'b01, 2'b00, 4'b0000};
            9:  return {2'b00, 2'b01, 2'b10, 2'b00, 4'b0000};
            10: return {2'b01, 2'b10, 2'b00, 2'b00, 4'b0000};
            default: return 12'h000;
        endcase
    endfunction

    // States visited after FETCH for a given opcode; the instruction then returns to FETCH.
    task automatic seqFor(input logic [6:0] o, output int q[$]);
        case (o)
            7'b0000011: q = '{1, 2, 3, 4};
            7'b0100011: q = '{1, 2, 5};
            7'b0110011: q = '{1, 6, 7};
            7'b0010011: q = '{1, 8, 7};
            7'b1101111: q = '{1, 9, 7};
            7'b1100011: q = '{1, 10};
            default:    q = '{1};
        endcase
    endtask

    function automatic logic isLegalOp(logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    int         expState;
    int         pending[$];
    logic [6:0] curOp;
    logic [6:0] opTable [7];
    int         instCount;

    initial begin
        opTable[0] = 7'b0000011;
        opTable[1] = 7'b0100011;
        opTable[2] = 7'b0110011;
        opTable[3] = 7'b0010011;
        opTable[4] = 7'b1101111;
        opTable[5] = 7'b1100011;
        opTable[6] = 7'b1111111;

        reset = 1'b1;
        op    = 7'd0;
        zero  = 1'b0;
        curOp = 7'd0;
        instCount = 0;
        repeat (2) @(posedge clk);
        expState = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (expState == 0) begin
                int pick;
                pick = $urandom_range(0, 7);
                if (instCount < 7) pick = instCount;
                curOp = (pick == 7) ? 7'($urandom) : opTable[pick];
                seqFor(curOp, pending);
                instCount++;
            end
            op    = (expState == 1 || expState == 2) ? curOp : 7'($urandom);
            zero  = 1'($urandom);
            reset = (cyc < 40) ? 1'b0 : ($urandom_range(0, 24) == 0);
            #1;
            chk("state", 32'(state), 32'(expState));
            chk("ctrl", 32'({aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, regWrite, memWrite}),
                32'(expCtrl(expState)));
            chk("pcWrite", 32'(pcWrite),
                32'((expState == 0) || (expState == 9) || (expState == 10 && zero)));
            chk("illegal", 32'(illegal), 32'(expState == 1 && !isLegalOp(curOp)));
            @(posedge clk);
            if (reset)                   expState = 0;
            else if (pending.size() > 0) expState = pending.pop_front();
            else                         expState = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
